// File: rtl/fmap_collector_pkg.sv
// Shared definitions for the feature-map collector: FSM state encodings,
// output-map size derivation and the default word width.
package fmap_collector_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int DATA_WIDTH_DEF = 32;

  // A 3x3 valid convolution shrinks the image by two pixels per axis.
  function automatic int out_w(input int width_img);
    return width_img - 2;
  endfunction

endpackage

// File: rtl/fmap_collector_ram.sv
// Simple dual-port frame store: synchronous write, one-cycle registered read.
// The read register holds its value whenever rd_en is low.
module fmap_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_collector.sv
// Collects one output feature map from the convolution engine into on-chip
// RAM, then replays it as a gap-free valid/data/last stream on request.
module fmap_collector
  import fmap_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WIDTH_IMG  = 28,
  parameter int ADDR_W     = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_start,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  frame_full,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [ADDR_W-1:0]     wr_row,
  output logic [ADDR_W-1:0]     wr_col
);

  localparam int OUT_W = out_w(WIDTH_IMG);
  localparam int WORDS = OUT_W * OUT_W;
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  generate
    if ((2 ** ADDR_W) < WORDS) begin : g_addr_check
      $error("fmap_collector: ADDR_W too small to hold OUT_W*OUT_W words");
    end
  endgenerate

  state_t                state;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_busy;
  logic                  wr_en;
  logic                  rd_en;
  logic                  last_rd;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  vld_p1;
  logic                  last_p1;

  // Word address runs as its own counter so no row*OUT_W multiply is needed.
  assign wr_en   = start && valid_in && (state == COLLECT);
  assign last_rd = (rd_addr == LAST_ADDR);
  // First read is issued on the same edge that accepts rd_start, so the
  // word appears on data_out two cycles after the request is sampled.
  assign rd_en   = start && (((state == FULL) && rd_start) ||
                             ((state == DRAIN) && rd_busy));

  fmap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_dout)
  );

  // FSM, write/read counters, status flags and read-side valid pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= COLLECT;
      wr_addr    <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      rd_addr    <= '0;
      rd_busy    <= 1'b0;
      frame_full <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
    end else if (start) begin
      frame_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (valid_in) begin
            if (wr_addr == LAST_ADDR) begin
              state      <= FULL;
              frame_done <= 1'b1;
              frame_full <= 1'b1;
              wr_addr    <= '0;
              wr_row     <= '0;
              wr_col     <= '0;
            end else begin
              wr_addr <= wr_addr + ONE;
              if (wr_col == LAST_COL) begin
                wr_col <= '0;
                wr_row <= wr_row + ONE;
              end else begin
                wr_col <= wr_col + ONE;
              end
            end
          end
        end
        FULL: begin
          if (valid_in) overflow <= 1'b1;
          if (rd_start) begin
            state      <= DRAIN;
            frame_full <= 1'b0;
            rd_addr    <= last_rd ? '0 : rd_addr + ONE;
            rd_busy    <= !last_rd;
          end
        end
        DRAIN: begin
          if (valid_in) overflow <= 1'b1;
          if (rd_busy) begin
            rd_addr <= last_rd ? '0 : rd_addr + ONE;
            rd_busy <= !last_rd;
          end
          if (last_out) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
      // stage p1: RAM read issued this edge
      vld_p1    <= rd_en;
      last_p1   <= rd_en && last_rd;
      // stage p2: RAM data registered onto the output
      valid_out <= vld_p1;
      last_out  <= last_p1;
    end
  end

  // Output data register, aligned with valid_out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
    end else if (start) begin
      data_out <= ram_dout;
    end
  end

endmodule

// File: tb/tb_fmap_collector.sv
// Directed bench for fmap_collector with a 6-pixel input image (4x4 map).
module tb_fmap_collector;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          rd_start;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          frame_full;
  logic          frame_done;
  logic          overflow;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] wr_col;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fmap_collector #(
    .DATA_WIDTH (DW),
    .WIDTH_IMG  (6),
    .ADDR_W     (AW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .rd_start   (rd_start),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .last_out   (last_out),
    .frame_full (frame_full),
    .frame_done (frame_done),
    .overflow   (overflow),
    .wr_row     (wr_row),
    .wr_col     (wr_col)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data_out"},   data_out,   32'd0);
    chk({tag, ".valid_out"},  valid_out,  32'd0);
    chk({tag, ".last_out"},   last_out,   32'd0);
    chk({tag, ".frame_full"}, frame_full, 32'd0);
    chk({tag, ".frame_done"}, frame_done, 32'd0);
    chk({tag, ".overflow"},   overflow,   32'd0);
    chk({tag, ".wr_row"},     wr_row,     32'd0);
    chk({tag, ".wr_col"},     wr_col,     32'd0);
  endtask

  // Writes words idx..idx+cnt-1 with value base+idx+1; optional 2 idle
  // cycles after each group of four.
  task automatic fill(input int base, input int idx, input int cnt, input bit gapped);
    for (int i = idx; i < idx + cnt; i++) begin
      valid_in = 1'b1;
      data_in  = DW'(base + i + 1);
      step();
      valid_in = 1'b0;
      if (gapped && (i % 4 == 3)) begin
        step();
        step();
      end
    end
  endtask

  // Requests a drain and checks 16 words base+1..base+16 with last on the
  // final one; optional 5-cycle start=0 freeze while word hold_at is shown.
  task automatic drain_check(input string tag, input int base, input int hold_at,
                             input logic exp_ovf);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk({tag, ".full_clr"}, frame_full, 32'd0);
    chk({tag, ".no_vld_t1"}, valid_out, 32'd0);
    step();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s.vld%0d", tag, k), valid_out, 32'd1);
      chk($sformatf("%s.dat%0d", tag, k), data_out, 32'(base + k + 1));
      chk($sformatf("%s.last%0d", tag, k), last_out, (k == 15) ? 32'd1 : 32'd0);
      if (k == hold_at) begin
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
          valid_in = j[0] ? 1'b0 : 1'b1;
          data_in  = 32'hDEAD;
          step();
          chk($sformatf("%s.hold_vld%0d", tag, j), valid_out, 32'd1);
          chk($sformatf("%s.hold_dat%0d", tag, j), data_out, 32'(base + k + 1));
          chk($sformatf("%s.hold_ovf%0d", tag, j), overflow, 32'(exp_ovf));
        end
        valid_in = 1'b0;
        start    = 1'b1;
      end
      step();
    end
    chk({tag, ".vld_end"}, valid_out, 32'd0);
    chk({tag, ".last_end"}, last_out, 32'd0);
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    rd_start = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    resetn = 1'b1;
    step();

    // Contiguous fill 1..16
    fill(0, 0, 5, 1'b0);
    chk("cont.row5", wr_row, 32'd1);
    chk("cont.col5", wr_col, 32'd1);
    fill(0, 5, 10, 1'b0);
    chk("cont.done15", frame_done, 32'd0);
    chk("cont.full15", frame_full, 32'd0);
    fill(0, 15, 1, 1'b0);
    chk("cont.done", frame_done, 32'd1);
    chk("cont.full", frame_full, 32'd1);
    chk("cont.row", wr_row, 32'd0);
    chk("cont.col", wr_col, 32'd0);
    step();
    chk("cont.done_pulse", frame_done, 32'd0);
    chk("cont.full_hold", frame_full, 32'd1);
    drain_check("drain1", 0, -1, 1'b0);

    // Gapped fill, starting the cycle right after last_out
    fill(32'hA00, 0, 4, 1'b1);
    chk("gap.row4", wr_row, 32'd1);
    chk("gap.col4", wr_col, 32'd0);
    fill(32'hA00, 4, 4, 1'b1);
    chk("gap.row8", wr_row, 32'd2);
    chk("gap.col8", wr_col, 32'd0);
    fill(32'hA00, 8, 3, 1'b1);
    chk("gap.row11", wr_row, 32'd2);
    chk("gap.col11", wr_col, 32'd3);
    fill(32'hA00, 11, 4, 1'b1);
    chk("gap.row15", wr_row, 32'd3);
    chk("gap.col15", wr_col, 32'd3);
    fill(32'hA00, 15, 1, 1'b0);
    chk("gap.done", frame_done, 32'd1);
    chk("gap.row", wr_row, 32'd0);
    chk("gap.col", wr_col, 32'd0);
    step();
    drain_check("drain_gap", 32'hA00, -1, 1'b0);

    // Enable hold mid-drain: valid_in toggling while start=0 is ignored
    fill(32'h200, 0, 16, 1'b0);
    chk("hold.full", frame_full, 32'd1);
    drain_check("drain_hold", 32'h200, 5, 1'b0);
    chk("hold.ovf", overflow, 32'd0);

    // Overflow in FULL; rd_start coinciding with the final write is ignored
    fill(0, 0, 15, 1'b0);
    valid_in = 1'b1;
    data_in  = 32'd16;
    rd_start = 1'b1;
    step();
    valid_in = 1'b0;
    rd_start = 1'b0;
    step();
    step();
    chk("ovf.ign_rd_vld", valid_out, 32'd0);
    chk("ovf.ign_rd_full", frame_full, 32'd1);
    chk("ovf.pre", overflow, 32'd0);
    valid_in = 1'b1;
    data_in  = 32'd99;
    step();
    valid_in = 1'b0;
    chk("ovf.set", overflow, 32'd1);
    drain_check("drain_ovf", 0, -1, 1'b1);
    chk("ovf.sticky", overflow, 32'd1);

    // Async reset after word 7
    fill(32'h300, 0, 7, 1'b0);
    chk("rst.row7", wr_row, 32'd1);
    chk("rst.col7", wr_col, 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    resetn = 1'b1;
    step();
    fill(32'h400, 0, 9, 1'b0);
    chk("refill.done9", frame_done, 32'd0);
    chk("refill.full9", frame_full, 32'd0);
    fill(32'h400, 9, 7, 1'b0);
    chk("refill.done16", frame_done, 32'd1);
    chk("refill.full16", frame_full, 32'd1);
    step();
    drain_check("drain_refill", 32'h400, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmap_collector.md
Name: fmap_collector

Overview:
- Receiving end of the convolution output stream: captures the valid-qualified result words of one output feature map ((WIDTH_IMG-2)^2 words, row-major) into on-chip storage.
- Once the frame is complete, re-transmits it as a gap-free stream in the same valid/data form, for the next layer's line buffer or for host readback.
- Sits directly after the convolution engine in each layer.

Parameters:
- DATA_WIDTH, 32, width of each feature word.
- WIDTH_IMG, 28, input image width of the producing layer; output map is OUT_W = WIDTH_IMG-2 square.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= OUT_W*OUT_W (checked at elaboration).

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; asynchronous, active-low.
- start  in  1  global pipeline enable; when low, all state and outputs hold.
- valid_in  in  1  input word strobe from the convolution engine.
- data_in  in  DATA_WIDTH  input feature word.
- rd_start  in  1  request to drain the stored frame.
- data_out  out  DATA_WIDTH  drained feature word.
- valid_out  out  1  qualifies data_out.
- last_out  out  1  high with the final drained word.
- frame_full  out  1  level; frame stored and not yet drained.
- frame_done  out  1  one-cycle pulse when the final word of a frame is written.
- overflow  out  1  sticky; an input word was dropped.
- wr_row  out  ADDR_W  current write row (0..OUT_W-1).
- wr_col  out  ADDR_W  current write column (0..OUT_W-1).

Behaviour:
- Reset values: data_out=0, valid_out=0, last_out=0, frame_full=0, frame_done=0, overflow=0, wr_row=0, wr_col=0; state=COLLECT; all counters 0. Reset mid-frame or mid-drain discards everything; RAM contents are don't-care.
- Enable rule: start=0 freezes state, counters and registered outputs. Inputs seen while start=0 are ignored, not counted as overflow.
- States: COLLECT, FULL, DRAIN.
- COLLECT:
  - Each valid_in=1 cycle writes data_in to RAM at wr_addr = wr_row*OUT_W + wr_col (kept as an incrementing counter, no multiplier).
  - Then wr_col++; when wr_col wraps from OUT_W-1 to 0, wr_row++.
  - Gaps (valid_in=0) are allowed anywhere.
  - On the write of word OUT_W*OUT_W-1: next state FULL, frame_done=1 for exactly the following cycle, frame_full=1 from that cycle, wr_row/wr_col return to 0.
- FULL:
  - valid_in=1 drops the word and sets overflow.
  - rd_start=1 moves to DRAIN next cycle and clears frame_full in that cycle.
- DRAIN:
  - Read address runs 0..OUT_W*OUT_W-1, one per cycle, no gaps. RAM read is synchronous.
  - valid_out rises 2 cycles after the rd_start sample edge, stays high exactly OUT_W*OUT_W cycles, and data_out matches write order.
  - last_out coincides with the final valid_out.
  - After the cycle carrying last_out, the state is COLLECT, and valid_in on the next cycle is accepted as word 0.
  - valid_in during DRAIN, including the last_out cycle, is dropped and sets overflow.
- rd_start outside FULL is ignored. If rd_start coincides with the final write in COLLECT, it is ignored; a new request is required in FULL.
- overflow clears only on reset.
- RAM: single write port and single read port; one write plus one read in the same cycle is never needed.

Decomposition:
- Shared package/include cnn_defs: state encodings COLLECT/FULL/DRAIN, OUT_W derivation macro, DATA_WIDTH default.
- One sub-module fmap_ram: simple dual-port, synchronous write and 1-cycle registered read, parameterised DATA_WIDTH/ADDR_W.
- Top level holds the FSM, counters and output registers.

Test Plan (WIDTH_IMG=6, OUT_W=4, 16 words):
- Contiguous fill: 16 back-to-back valid_in with data 1..16 -> frame_done pulses once the cycle after word 16; frame_full=1; wr_row/wr_col read 0/0.
- Drain: rd_start at cycle T in FULL -> valid_out high at T+2..T+17, data_out 1..16 in order, last_out only at T+17, frame_full=0 from T+1.
- Gapped fill: words 1..16 with 2 idle cycles after every 4 (the engine's end-of-row gaps) -> wr_col wraps at 4, wr_row steps 0..3, drained data is 1..16.
- Overflow: extra valid_in (data 99) in FULL, then drain -> overflow=1 and stays set; drained stream is still 1..16 with no 99.
- Enable hold: start=0 for 5 cycles mid-drain with valid_in toggling -> valid_out/data_out frozen; drain resumes with no skipped or repeated word; overflow unchanged.
- Async reset during collection after word 7 -> all outputs 0 immediately; refill with 16 words gives frame_done after 16, not 9.
